disp_vram_rdctrl: RTL and testbench



---
 rtl/disp_vram_rdctrl.sv | 154 +++++++++++++++
 tb/tb_disp_vram_rdctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_vram_rdctrl.sv
// Display VRAM read controller: fetches one frame per VBLANK over AXI4
// read bursts and feeds the 24-bit RGB payload into the pixel FIFO.
module disp_vram_rdctrl #(
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned FREE_W    = 10
) (
  input  logic              ACLK,
  input  logic              ARST,
  input  logic              DISPON,
  input  logic [31:0]       DISPADDR,
  input  logic [1:0]        RESOL,
  input  logic              VSTART,
  input  logic [FREE_W-1:0] FIFO_FREE,
  output logic              FIFO_WR,
  output logic [23:0]       FIFO_WDATA,
  output logic [31:0]       ARADDR,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [31:0]       RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic              LATE,
  output logic              RESP_ERR
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    REQ,
    DATA
  } state_e;

  localparam logic [16:0] VGA_N  = 17'd19200;
  localparam logic [16:0] XGA_N  = 17'd49152;
  localparam logic [16:0] SXGA_N = 17'd81920;
  localparam logic [31:0] STEP   = 32'(BURST_LEN * 4);
  localparam logic [31:0] NEED   = 32'(BURST_LEN);

  state_e      state_q;
  logic [31:0] addr_q;
  logic [16:0] cnt_q;
  logic        arvalid_q;
  logic        rready_q;
  logic        fifo_wr_q;
  logic [23:0] fifo_wdata_q;
  logic        frame_done_q;
  logic        late_q;
  logic        resp_err_q;

  logic [31:0] addr_d;
  logic [16:0] cnt_d;
  logic [16:0] frame_n_d;
  logic        space_ok;
  logic        unused_bits;

  assign addr_d   = addr_q + STEP;
  assign cnt_d    = cnt_q - 17'd1;
  assign space_ok = 32'(FIFO_FREE) >= NEED;

  // Low address bits and the X byte are dropped on purpose
  assign unused_bits = ^{DISPADDR[5:0], RDATA[31:24]};

  always_comb begin
    frame_n_d = VGA_N;
    unique case (RESOL)
      2'b01:   frame_n_d = XGA_N;
      2'b10:   frame_n_d = SXGA_N;
      default: frame_n_d = VGA_N;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      fifo_wr_q    <= 1'b0;
      fifo_wdata_q <= '0;
      frame_done_q <= 1'b0;
      late_q       <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      fifo_wr_q    <= 1'b0;
      frame_done_q <= 1'b0;
      late_q       <= VSTART && (state_q != IDLE);
      if (RVALID && rready_q && (RRESP != 2'b00))
        resp_err_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (VSTART && DISPON) begin
            addr_q  <= {DISPADDR[31:6], 6'b0};
            cnt_q   <= frame_n_d;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (cnt_q == 17'd0) begin
            frame_done_q <= 1'b1;
            state_q      <= IDLE;
          end else if (!DISPON) begin
            state_q <= IDLE;
          end else if (space_ok) begin
            arvalid_q <= 1'b1;
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (RVALID) begin
            fifo_wr_q    <= 1'b1;
            fifo_wdata_q <= RDATA[23:0];
            // Only RLAST closes the burst; beats are not counted
            if (RLAST) begin
              rready_q <= 1'b0;
              addr_q   <= addr_d;
              cnt_q    <= cnt_d;
              state_q  <= CHECK;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign FIFO_WR    = fifo_wr_q;
  assign FIFO_WDATA = fifo_wdata_q;
  assign ARADDR     = addr_q;
  assign ARLEN      = 8'(BURST_LEN - 1);
  assign ARSIZE     = 3'b010;
  assign ARBURST    = 2'b01;
  assign ARVALID    = arvalid_q;
  assign RREADY     = rready_q;
  assign BUSY       = state_q != IDLE;
  assign FRAME_DONE = frame_done_q;
  assign LATE       = late_q;
  assign RESP_ERR   = resp_err_q;

endmodule

// File: tb/tb_disp_vram_rdctrl.sv
// Scoreboard bench for disp_vram_rdctrl with a behavioural AXI read slave.
`timescale 1ns/1ps
module tb_disp_vram_rdctrl;

  logic        ACLK;
  logic        ARST;
  logic        DISPON;
  logic [31:0] DISPADDR;
  logic [1:0]  RESOL;
  logic        VSTART;
  logic [9:0]  FIFO_FREE;
  logic        FIFO_WR;
  logic [23:0] FIFO_WDATA;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic        BUSY;
  logic        FRAME_DONE;
  logic        LATE;
  logic        RESP_ERR;

  disp_vram_rdctrl #(.BURST_LEN(16), .FREE_W(10)) dut (
    .ACLK(ACLK), .ARST(ARST), .DISPON(DISPON), .DISPADDR(DISPADDR),
    .RESOL(RESOL), .VSTART(VSTART), .FIFO_FREE(FIFO_FREE),
    .FIFO_WR(FIFO_WR), .FIFO_WDATA(FIFO_WDATA), .ARADDR(ARADDR),
    .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .RDATA(RDATA), .RRESP(RRESP),
    .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY), .BUSY(BUSY),
    .FRAME_DONE(FRAME_DONE), .LATE(LATE), .RESP_ERR(RESP_ERR)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [31:0] exp_ar[$];
  logic [23:0] exp_px[$];

  int ar_cnt   = 0;
  int px_cnt   = 0;
  int fd_cnt   = 0;
  int late_cnt = 0;
  bit arv_seen = 0;

  // slave knobs
  int nbeats  = 16;
  bit stall   = 0;
  bit err_req = 0;

  // AXI read slave: memory word at a is {C3, a[25:2]}
  initial begin
    automatic bit          ar_go = 0;
    automatic bit          r_go = 0;
    automatic bit          in_burst = 0;
    automatic int          beat = 0;
    automatic logic [31:0] cur = 0;
    automatic logic [31:0] nxt = 0;
    automatic logic [31:0] a;
    ARREADY = 0; RVALID = 0; RLAST = 0; RDATA = 0; RRESP = 0;
    forever begin
      @(negedge ACLK);
      if (ARST) begin
        ar_go = 0; r_go = 0; in_burst = 0;
        ARREADY = 0; RVALID = 0; RLAST = 0;
        continue;
      end
      if (r_go) begin
        beat++;
        if (RLAST) in_burst = 0;
      end
      if (ar_go) begin
        in_burst = 1;
        beat = 0;
        cur = nxt;
      end
      if (!(RVALID && !r_go)) begin
        RVALID = in_burst && (!stall || $urandom_range(0, 3) != 0);
        a = cur + 32'(beat) * 4;
        RDATA = {8'hC3, a[25:2]};
        RLAST = (beat == nbeats - 1);
        RRESP = 2'b00;
        if (RVALID && err_req) begin
          RRESP = 2'b10;
          err_req = 0;
        end
      end
      ARREADY = !in_burst && (!stall || $urandom_range(0, 1) != 0);
      ar_go = ARVALID && ARREADY;
      if (ar_go) nxt = ARADDR;
      r_go = RVALID && RREADY;
      if (r_go) exp_px.push_back(RDATA[23:0]);
    end
  end

  // monitor
  initial begin
    automatic bit          pend = 0;
    automatic logic [31:0] pend_addr = 0;
    forever begin
      @(negedge ACLK);
      #2;
      if (ARST) begin
        pend = 0;
        continue;
      end
      if (pend) begin
        chk("ar_hold_valid", ARVALID, 1);
        chk("ar_hold_addr", ARADDR, pend_addr);
      end
      pend = ARVALID && !ARREADY;
      pend_addr = ARADDR;
      if (ARVALID) arv_seen = 1;
      if (ARVALID && ARREADY) begin
        ar_cnt++;
        if (exp_ar.size() == 0) begin
          total++; bad++;
          $display("FAIL ar_extra: got %h expected none", ARADDR);
        end else begin
          chk("araddr", ARADDR, exp_ar.pop_front());
          chk("ar_attr", {ARLEN, ARSIZE, ARBURST},
              {8'd15, 3'b010, 2'b01});
        end
      end
      if (FIFO_WR) begin
        px_cnt++;
        if (exp_px.size() == 0) begin
          total++; bad++;
          $display("FAIL px_extra: got %h expected none", FIFO_WDATA);
        end else begin
          chk("fifo_wdata", FIFO_WDATA, exp_px.pop_front());
        end
      end
      if (FRAME_DONE) fd_cnt++;
      if (LATE) late_cnt++;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge ACLK);
      #4;
    end
  endtask

  task automatic pulse_vstart();
    VSTART = 1;
    step();
    VSTART = 0;
  endtask

  initial begin
    int a0, p0, f0, l0, w;
    ARST = 1; DISPON = 0; DISPADDR = 0; RESOL = 0;
    VSTART = 0; FIFO_FREE = 10'd512;
    step(3);
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_rready", RREADY, 0);
    chk("rst_fifo_wr", FIFO_WR, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_flags", {FRAME_DONE, LATE, RESP_ERR}, 0);
    chk("rst_araddr", ARADDR, 0);
    chk("rst_wdata", FIFO_WDATA, 0);
    ARST = 0;
    step();

    // full VGA frame, single-beat bursts to keep run time short
    DISPON = 1; DISPADDR = 0; RESOL = 2'b00; nbeats = 1; stall = 0;
    for (int i = 0; i < 19200; i++) exp_ar.push_back(32'(i) * 64);
    pulse_vstart();
    for (int i = 0; i < 70000 && fd_cnt == 0; i++) step();
    chk("vga_frame_done", fd_cnt, 1);
    chk("vga_ar_count", ar_cnt, 19200);
    chk("vga_px_count", px_cnt, 19200);
    chk("vga_ar_left", exp_ar.size(), 0);
    step(3);
    chk("vga_busy_after", BUSY, 0);
    chk("vga_done_once", fd_cnt, 1);

    // VSTART with display off is ignored
    DISPON = 0;
    pulse_vstart();
    step(2);
    chk("off_busy", BUSY, 0);
    chk("off_late", late_cnt, 0);

    // FIFO space gating
    arv_seen = 0; a0 = ar_cnt; p0 = px_cnt; f0 = fd_cnt;
    DISPON = 1; DISPADDR = 32'h0000_1000; nbeats = 16; FIFO_FREE = 10'd15;
    pulse_vstart();
    step(20);
    chk("free15_no_ar", arv_seen, 0);
    chk("free15_busy", BUSY, 1);
    exp_ar.push_back(32'h0000_1000);
    FIFO_FREE = 10'd16;
    w = 0;
    while (!ARVALID && w < 4) begin
      step();
      w++;
    end
    chk("free16_ar_latency_ok", (w >= 1 && w <= 2), 1);
    for (int i = 0; i < 400 && px_cnt < p0 + 16; i++) step();
    chk("burst16_px", px_cnt, p0 + 16);

    // stalls, VSTART while busy, then DISPON drop mid-burst
    stall = 1; FIFO_FREE = 10'd512; l0 = late_cnt;
    exp_ar.push_back(32'h0000_1040);
    exp_ar.push_back(32'h0000_1080);
    exp_ar.push_back(32'h0000_10C0);
    exp_ar.push_back(32'h0000_1100);
    for (int i = 0; i < 2000 && ar_cnt < a0 + 3; i++) step();
    pulse_vstart();
    step(2);
    chk("late_once", late_cnt, l0 + 1);
    for (int i = 0; i < 3000 && !(ar_cnt == a0 + 5 && px_cnt >= p0 + 69); i++)
      step();
    DISPON = 0;
    for (int i = 0; i < 1000 && px_cnt < p0 + 80; i++) step();
    chk("drop_px_total", px_cnt, p0 + 80);
    chk("drop_in_check", BUSY, 1);
    step();
    chk("drop_idle", BUSY, 0);
    step(5);
    chk("drop_ar_total", ar_cnt, a0 + 5);
    chk("drop_no_done", fd_cnt, f0);
    chk("drop_ar_left", exp_ar.size(), 0);
    chk("drop_px_left", exp_px.size(), 0);
    chk("late_total", late_cnt, l0 + 1);

    // address wrap, XGA, error response
    a0 = ar_cnt; p0 = px_cnt;
    stall = 0; nbeats = 1; err_req = 1;
    DISPON = 1; DISPADDR = 32'hFFFF_FFE5; RESOL = 2'b01;
    exp_ar.push_back(32'hFFFF_FFC0);
    exp_ar.push_back(32'h0000_0000);
    exp_ar.push_back(32'h0000_0040);
    pulse_vstart();
    for (int i = 0; i < 100 && ar_cnt < a0 + 3; i++) step();
    DISPON = 0;
    for (int i = 0; i < 20 && BUSY; i++) step();
    chk("wrap_idle", BUSY, 0);
    chk("wrap_ar_total", ar_cnt, a0 + 3);
    chk("wrap_px_total", px_cnt, p0 + 3);
    chk("resp_err_set", RESP_ERR, 1);

    // next frame keeps the sticky error
    a0 = ar_cnt;
    DISPON = 1; DISPADDR = 32'h0000_2000; RESOL = 2'b11;
    exp_ar.push_back(32'h0000_2000);
    exp_ar.push_back(32'h0000_2040);
    pulse_vstart();
    for (int i = 0; i < 100 && ar_cnt < a0 + 2; i++) step();
    DISPON = 0;
    for (int i = 0; i < 20 && BUSY; i++) step();
    chk("err_frame_idle", BUSY, 0);
    chk("err_frame_ars", ar_cnt, a0 + 2);
    chk("resp_err_held", RESP_ERR, 1);
    chk("done_total", fd_cnt, 1);
    ARST = 1;
    step();
    chk("resp_err_cleared", RESP_ERR, 0);
    chk("rst2_busy", BUSY, 0);
    ARST = 0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
